bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/mips32_bus_pkg.sv | 16 +
 rtl/bus_watchdog.sv | 31 +++
 rtl/bus_arbiter.sv | 115 +++++++++++
 tb/tb_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_bus_pkg.sv
// rtl/mips32_bus_pkg.sv - shared state encoding and defaults for the bus arbiter
package mips32_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_DROP = 3'd3,
    I_RESP = 3'd4,
    D_RESP = 3'd5
  } bus_state_t;

  localparam int         TIMEOUT_CYC_DEF = 255;
  localparam logic [3:0] FETCH_WSEL      = 4'hF;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - counts stalled bus cycles, flags expiry on the last allowed one
module bus_watchdog
  import mips32_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Combinational so the arbiter can abort on the same edge the limit is hit.
  assign expired = run && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - single-master bus arbiter between fetch and load/store ports
module bus_arbiter
  import mips32_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_stall_req,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wsel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_stall_req,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_wsel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  bus_state_t state;
  logic       grant;
  logic       wd_expired;

  assign grant = (state == IDLE) && (d_req || (i_req && !flush));

  bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (bus_req && !bus_ack),
    .clr     (grant || bus_ack),
    .expired (wd_expired)
  );

  assign i_stall_req = i_req && (state != I_RESP);
  assign d_stall_req = d_req && (state != D_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_wsel  <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      i_rdata   <= 32'h0;
      d_rdata   <= 32'h0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          // Data first: it belongs to the older instruction in the pipeline.
          if (d_req) begin
            bus_req   <= 1'b1;
            bus_we    <= d_we;
            bus_wsel  <= d_wsel;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            state     <= D_BUSY;
          end else if (i_req && !flush) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_wsel  <= FETCH_WSEL;
            bus_addr  <= i_addr;
            bus_wdata <= 32'h0;
            state     <= I_BUSY;
          end
        end
        I_BUSY: begin
          if (bus_ack || wd_expired) begin
            bus_req <= 1'b0;
            bus_err <= wd_expired;
            if (flush) begin
              state <= IDLE;
            end else begin
              i_rdata <= bus_ack ? bus_rdata : 32'h0;
              state   <= I_RESP;
            end
          end else if (flush) begin
            state <= I_DROP;
          end
        end
        I_DROP: begin
          // Bus cycle runs to completion; the returned word is discarded.
          if (bus_ack || wd_expired) begin
            bus_req <= 1'b0;
            bus_err <= wd_expired;
            state   <= IDLE;
          end
        end
        D_BUSY: begin
          if (bus_ack || wd_expired) begin
            bus_req <= 1'b0;
            bus_err <= wd_expired;
            d_rdata <= bus_ack ? bus_rdata : 32'h0;
            state   <= D_RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with transaction-level model
module tb_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, flush, bus_ack;
  logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_wsel;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
  logic        i_stall_req, d_stall_req, bus_req, bus_we, bus_err;
  logic [3:0]  bus_wsel;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Transaction-level view: is a bus cycle open, who owns it, was it flushed,
  // how long it has waited, and which port (if any) sees its response now.
  bit          m_busy, m_is_data, m_dropped, m_err;
  int          m_wait, m_resp;
  logic [31:0] m_addr, m_wdata, m_i_rdata, m_d_rdata;
  logic [3:0]  m_wsel;
  logic        m_we;

  bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall_req(i_stall_req),
    .d_req(d_req), .d_we(d_we), .d_wsel(d_wsel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall_req(d_stall_req), .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_wsel(bus_wsel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_is_data = 0; m_dropped = 0; m_err = 0;
    m_wait = 0; m_resp = 0;
    m_addr = 0; m_wdata = 0; m_wsel = 0; m_we = 0;
    m_i_rdata = 0; m_d_rdata = 0;
  endtask

  task automatic open_txn(input bit is_data, input logic [31:0] a, input logic we,
                          input logic [3:0] ws, input logic [31:0] wd);
    m_busy = 1; m_is_data = is_data; m_dropped = 0; m_wait = 0;
    m_addr = a; m_we = we; m_wsel = ws; m_wdata = wd;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_err = 0;
      if (m_busy) begin
        if (bus_ack || (m_wait + 1 == TO)) begin
          m_busy = 0;
          m_err  = !bus_ack;
          if (m_is_data) begin
            m_d_rdata = bus_ack ? bus_rdata : 32'h0;
            m_resp    = 2;
          end else if (!(m_dropped || flush)) begin
            m_i_rdata = bus_ack ? bus_rdata : 32'h0;
            m_resp    = 1;
          end
        end else begin
          m_wait++;
          if (!m_is_data && flush) m_dropped = 1;
        end
      end else if (m_resp != 0) begin
        m_resp = 0;
      end else if (d_req) begin
        open_txn(1, d_addr, d_we, d_wsel, d_wdata);
      end else if (i_req && !flush) begin
        open_txn(0, i_addr, 1'b0, 4'hF, 32'h0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("bus_req",   bus_req,   m_busy);
      chk("bus_we",    bus_we,    m_we);
      chk("bus_wsel",  bus_wsel,  m_wsel);
      chk("bus_addr",  bus_addr,  m_addr);
      chk("bus_wdata", bus_wdata, m_wdata);
      chk("bus_err",   bus_err,   m_err);
      chk("i_rdata",   i_rdata,   m_i_rdata);
      chk("d_rdata",   d_rdata,   m_d_rdata);
      chk("i_stall",   i_stall_req, i_req && (m_resp != 1));
      chk("d_stall",   d_stall_req, d_req && (m_resp != 2));
    end
  end

  initial begin
    int n;
    rst_n = 1; i_req = 0; d_req = 0; d_we = 0; flush = 0; bus_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wsel = 0; bus_rdata = 0;
    model_reset();
    #1 rst_n = 0;
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wsel", bus_wsel, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    check_en = 1;
    tick(); rst_n = 1;
    tick();

    // Single fetch, ack two cycles after bus_req rises
    i_req = 1; i_addr = 32'h10;
    tick();
    @(negedge clk);
    chk("f_bus_req", bus_req, 1);
    chk("f_bus_addr", bus_addr, 32'h10);
    chk("f_bus_wsel", bus_wsel, 4'hF);
    tick(); tick(); bus_ack = 1; bus_rdata = 32'h2408_0001;
    @(negedge clk);
    chk("f_stall_at_ack", i_stall_req, 1);
    tick(); bus_ack = 0;
    @(negedge clk);
    chk("f_i_rdata", i_rdata, 32'h2408_0001);
    chk("f_stall_low", i_stall_req, 0);
    tick();
    @(negedge clk);
    chk("f_stall_after", i_stall_req, 1);
    #1 i_req = 0;
    tick();

    // Simultaneous requests: store goes first, then the fetch
    i_req = 1; i_addr = 32'h40;
    d_req = 1; d_addr = 32'h100; d_we = 1; d_wdata = 32'hDEAD_BEEF; d_wsel = 4'h3;
    tick(); bus_ack = 1; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("s_bus_addr", bus_addr, 32'h100);
    chk("s_bus_we", bus_we, 1);
    chk("s_bus_wsel", bus_wsel, 4'h3);
    chk("s_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("s_i_stall", i_stall_req, 1);
    tick(); bus_ack = 0; d_req = 0; d_we = 0;
    @(negedge clk);
    chk("s_d_rdata", d_rdata, 32'h1234_5678);
    chk("s_i_stall_resp", i_stall_req, 1);
    tick();
    tick(); bus_ack = 1; bus_rdata = 32'hCAFE_0001;
    @(negedge clk);
    chk("s_fetch_addr", bus_addr, 32'h40);
    chk("s_fetch_we", bus_we, 0);
    tick(); bus_ack = 0; i_req = 0;
    @(negedge clk);
    chk("s_fetch_rdata", i_rdata, 32'hCAFE_0001);
    tick();

    // Flush one cycle after fetch grant; ack three cycles later is discarded
    i_req = 1; i_addr = 32'h80;
    tick(); flush = 1;
    tick(); flush = 0;
    tick(); tick(); bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("fl_req_held", bus_req, 1);
    tick(); bus_ack = 0;
    @(negedge clk);
    chk("fl_i_rdata_kept", i_rdata, 32'hCAFE_0001);
    chk("fl_no_resp", i_stall_req, 1);
    tick();
    @(negedge clk);
    chk("fl_regrant", bus_req, 1);
    chk("fl_regrant_addr", bus_addr, 32'h80);
    #1 bus_ack = 1; bus_rdata = 32'h0000_0080;
    tick(); bus_ack = 0; i_req = 0;
    tick();

    // Watchdog: never ack a load
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus_req) break;
      n++;
      tick();
    end
    chk("to_req_cycles", n, TO);
    chk("to_bus_err", bus_err, 1);
    chk("to_d_rdata", d_rdata, 0);
    chk("to_d_stall", d_stall_req, 0);
    #1 d_req = 0;
    tick();
    @(negedge clk);
    chk("to_err_pulse", bus_err, 0);
    tick();

    // Reset during a data cycle, then a stale ack after release
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h55; d_wsel = 4'hF;
    tick(); tick();
    rst_n = 0; model_reset();
    @(negedge clk);
    chk("mr_bus_req", bus_req, 0);
    chk("mr_bus_addr", bus_addr, 0);
    chk("mr_bus_wdata", bus_wdata, 0);
    chk("mr_bus_wsel", bus_wsel, 0);
    chk("mr_i_rdata", i_rdata, 0);
    tick(); rst_n = 1; bus_ack = 1; bus_rdata = 32'h77;
    @(negedge clk);
    chk("mr_idle_stall", d_stall_req, 1);
    tick(); bus_ack = 0;
    @(negedge clk);
    chk("mr_fresh_grant", bus_req, 1);
    chk("mr_ack_ignored", d_rdata, 0);
    #1 bus_ack = 1;
    tick(); bus_ack = 0; d_req = 0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 249) != 0);
      if (!rst_n) model_reset();
      i_req     = ($urandom_range(0, 9) < 6);
      d_req     = ($urandom_range(0, 9) < 3);
      flush     = ($urandom_range(0, 9) == 0);
      d_we      = 1'($urandom);
      d_wsel    = 4'($urandom);
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      bus_ack   = ($urandom_range(0, 9) < 3);
      bus_rdata = $urandom;
    end

    tick();
    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
